// File: rtl/regfile_rename_ckpt_pkg.sv
// Shared defaults and tag-table operation encoding for the renaming register file.
package regfile_rename_ckpt_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int NREG_DEF     = 32;
  localparam int ROB_W_DEF    = 4;
  localparam int NUM_RD_DEF   = 2;
  localparam int NUM_CKPT_DEF = 4;

  // Source of the next tag table, in priority order flush > recover > normal update.
  typedef enum logic [1:0] {
    Q_HOLD,
    Q_UPDATE,
    Q_RESTORE,
    Q_CLEAR
  } qop_e;

endpackage

// File: rtl/regfile_rename_ckpt_ckpt_bank.sv
// Checkpoint storage: NUM_CKPT snapshots of the rename tag table, with save,
// commit-clear across all slots, and a combinational read of one slot.
module regfile_rename_ckpt_ckpt_bank #(
  parameter int NREG     = 32,
  parameter int ROB_W    = 4,
  parameter int NUM_CKPT = 4,
  localparam int REG_W   = $clog2(NREG),
  localparam int CK_W    = $clog2(NUM_CKPT)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        save_i,
  input  logic [CK_W-1:0]             save_id_i,
  input  logic [NREG-1:0][ROB_W-1:0]  save_tags_i,
  input  logic                        clr_i,
  input  logic [REG_W-1:0]            clr_rd_i,
  input  logic [ROB_W-1:0]            clr_tag_i,
  input  logic [CK_W-1:0]             rd_id_i,
  output logic [NREG-1:0][ROB_W-1:0]  rd_tags_o
);

  logic [NUM_CKPT-1:0][NREG-1:0][ROB_W-1:0] slot_q;

  // A save to the same slot as a clear wins; the saved table already has the clear applied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
    end else begin
      if (clr_i) begin
        for (int s = 0; s < NUM_CKPT; s++) begin
          if (slot_q[s][clr_rd_i] == clr_tag_i) slot_q[s][clr_rd_i] <= '0;
        end
      end
      if (save_i) slot_q[save_id_i] <= save_tags_i;
    end
  end

  assign rd_tags_o = slot_q[rd_id_i];

endmodule

// File: rtl/regfile_rename_ckpt.sv
// Architectural register file with per-register rename tags, commit bypass on
// the read ports and a ring of tag-table checkpoints for branch recovery.
module regfile_rename_ckpt
  import regfile_rename_ckpt_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREG     = NREG_DEF,
  parameter int ROB_W    = ROB_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int NUM_CKPT = NUM_CKPT_DEF,
  localparam int REG_W   = $clog2(NREG),
  localparam int CK_W    = $clog2(NUM_CKPT),
  localparam int CNT_W   = CK_W + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic [NUM_RD*REG_W-1:0] rd_idx_i,
  output logic [NUM_RD*XLEN-1:0]  rd_val_o,
  output logic [NUM_RD*ROB_W-1:0] rd_tag_o,
  input  logic                    alloc_i,
  input  logic [REG_W-1:0]        alloc_rd_i,
  input  logic [ROB_W-1:0]        alloc_tag_i,
  input  logic                    ckpt_req_i,
  output logic                    ckpt_ack_o,
  output logic [CK_W-1:0]         ckpt_id_o,
  output logic                    ckpt_full_o,
  input  logic                    commit_i,
  input  logic [REG_W-1:0]        commit_rd_i,
  input  logic [ROB_W-1:0]        commit_tag_i,
  input  logic [XLEN-1:0]         commit_val_i,
  input  logic                    recover_i,
  input  logic [CK_W-1:0]         recover_id_i,
  input  logic                    release_i,
  input  logic                    flush_i
);

  logic [XLEN-1:0]            v_q [NREG];
  logic [NREG-1:0][ROB_W-1:0] q_q, q_d, ckpt_tags;
  logic [CK_W-1:0]            head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic                       commit_en, alloc_en, rel_en, ack;
  qop_e                       qop;

  assign commit_en = commit_i & (commit_rd_i != '0);
  assign alloc_en  = alloc_i & (alloc_rd_i != '0) & ~flush_i & ~recover_i;
  assign rel_en    = release_i & (count_q != '0);
  // A release in the same cycle frees the head slot, so a full ring can still accept.
  assign ack       = ~rst & rdy & ckpt_req_i & ~flush_i & ~recover_i &
                     ((count_q < CNT_W'(NUM_CKPT)) | release_i);

  assign ckpt_ack_o  = ack;
  assign ckpt_id_o   = tail_q;
  assign ckpt_full_o = (count_q == CNT_W'(NUM_CKPT));

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [REG_W-1:0] idx;
    logic [XLEN-1:0]  val;
    logic [ROB_W-1:0] tag;
    assign idx = rd_idx_i[p*REG_W +: REG_W];
    always_comb begin
      val = v_q[idx];
      tag = q_q[idx];
      if (idx == '0) begin
        val = '0;
        tag = '0;
      end else if (commit_i && commit_rd_i == idx) begin
        val = commit_val_i;
        tag = (q_q[idx] == commit_tag_i) ? '0 : q_q[idx];
      end
    end
    assign rd_val_o[p*XLEN +: XLEN]   = val;
    assign rd_tag_o[p*ROB_W +: ROB_W] = tag;
  end

  always_comb begin
    qop = Q_HOLD;
    if (rdy) begin
      if (flush_i)        qop = Q_CLEAR;
      else if (recover_i) qop = Q_RESTORE;
      else                qop = Q_UPDATE;
    end
  end

  always_comb begin
    q_d = q_q;
    unique case (qop)
      Q_CLEAR: q_d = '0;
      Q_RESTORE: begin
        q_d = ckpt_tags;
        if (commit_en && ckpt_tags[commit_rd_i] == commit_tag_i) q_d[commit_rd_i] = '0;
      end
      Q_UPDATE: begin
        if (commit_en && q_q[commit_rd_i] == commit_tag_i) q_d[commit_rd_i] = '0;
        if (alloc_en) q_d[alloc_rd_i] = alloc_tag_i;
      end
      default: q_d = q_q;
    endcase
    q_d[0] = '0;
  end

  // Recovery keeps slots head..id live; a release only advances head if it is not the restored slot.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (recover_i) begin
      if (rel_en && head_q != recover_id_i) head_d = head_q + CK_W'(1);
      tail_d  = recover_id_i + CK_W'(1);
      count_d = {1'b0, recover_id_i - head_d} + CNT_W'(1);
    end else begin
      if (rel_en) head_d = head_q + CK_W'(1);
      if (ack)    tail_d = tail_q + CK_W'(1);
      count_d = count_q - CNT_W'(rel_en) + CNT_W'(ack);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q     <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < NREG; i++) v_q[i] <= '0;
    end else if (rdy) begin
      q_q     <= q_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (commit_en) v_q[commit_rd_i] <= commit_val_i;
    end
  end

  regfile_rename_ckpt_ckpt_bank #(
    .NREG     (NREG),
    .ROB_W    (ROB_W),
    .NUM_CKPT (NUM_CKPT)
  ) u_ckpt_bank (
    .clk         (clk),
    .rst         (rst),
    .save_i      (ack),
    .save_id_i   (tail_q),
    .save_tags_i (q_d),
    .clr_i       (rdy & commit_en),
    .clr_rd_i    (commit_rd_i),
    .clr_tag_i   (commit_tag_i),
    .rd_id_i     (recover_id_i),
    .rd_tags_o   (ckpt_tags)
  );

endmodule

// File: tb/tb_regfile_rename_ckpt.sv
// Directed bench for regfile_rename_ckpt: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_regfile_rename_ckpt;

  localparam int XLEN = 32, NREG = 32, ROB_W = 4, NUM_RD = 2, NUM_CKPT = 4;
  localparam int REG_W = $clog2(NREG), CK_W = $clog2(NUM_CKPT);
  localparam int K_V0 = 0, K_T0 = 1, K_V1 = 2, K_T1 = 3, K_ACK = 4, K_ID = 5, K_FULL = 6;

  logic                    clk, rst, rdy;
  logic [NUM_RD*REG_W-1:0] rd_idx_i;
  logic [NUM_RD*XLEN-1:0]  rd_val_o;
  logic [NUM_RD*ROB_W-1:0] rd_tag_o;
  logic                    alloc_i;
  logic [REG_W-1:0]        alloc_rd_i;
  logic [ROB_W-1:0]        alloc_tag_i;
  logic                    ckpt_req_i, ckpt_ack_o, ckpt_full_o;
  logic [CK_W-1:0]         ckpt_id_o;
  logic                    commit_i;
  logic [REG_W-1:0]        commit_rd_i;
  logic [ROB_W-1:0]        commit_tag_i;
  logic [XLEN-1:0]         commit_val_i;
  logic                    recover_i, release_i, flush_i;
  logic [CK_W-1:0]         recover_id_i;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  regfile_rename_ckpt #(
    .XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W), .NUM_RD(NUM_RD), .NUM_CKPT(NUM_CKPT)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .rd_idx_i(rd_idx_i), .rd_val_o(rd_val_o), .rd_tag_o(rd_tag_o),
    .alloc_i(alloc_i), .alloc_rd_i(alloc_rd_i), .alloc_tag_i(alloc_tag_i),
    .ckpt_req_i(ckpt_req_i), .ckpt_ack_o(ckpt_ack_o), .ckpt_id_o(ckpt_id_o),
    .ckpt_full_o(ckpt_full_o),
    .commit_i(commit_i), .commit_rd_i(commit_rd_i), .commit_tag_i(commit_tag_i),
    .commit_val_i(commit_val_i),
    .recover_i(recover_i), .recover_id_i(recover_id_i),
    .release_i(release_i), .flush_i(flush_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] observe(int kind);
    case (kind)
      K_V0:    return rd_val_o[31:0];
      K_T0:    return 32'(rd_tag_o[3:0]);
      K_V1:    return rd_val_o[63:32];
      K_T1:    return 32'(rd_tag_o[7:4]);
      K_ACK:   return 32'(ckpt_ack_o);
      K_ID:    return 32'(ckpt_id_o);
      default: return 32'(ckpt_full_o);
    endcase
  endfunction

  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = observe(e.kind);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
      end
    end
  end

  task automatic idle();
    rdy = 1'b1; alloc_i = 1'b0; alloc_rd_i = '0; alloc_tag_i = '0;
    ckpt_req_i = 1'b0; commit_i = 1'b0; commit_rd_i = '0; commit_tag_i = '0;
    commit_val_i = '0; recover_i = 1'b0; recover_id_i = '0; release_i = 1'b0;
    flush_i = 1'b0; rd_idx_i = '0;
  endtask

  task automatic expect_(input int k, input logic [31:0] v, input string n);
    sb.push_back('{k, v, n});
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int p0, input int p1);
    rd_idx_i = {REG_W'(p1), REG_W'(p0)};
  endtask

  task automatic alloc(input int r, input int t);
    alloc_i = 1'b1; alloc_rd_i = REG_W'(r); alloc_tag_i = ROB_W'(t);
  endtask

  task automatic do_commit(input int r, input int t, input logic [31:0] v);
    commit_i = 1'b1; commit_rd_i = REG_W'(r); commit_tag_i = ROB_W'(t); commit_val_i = v;
  endtask

  task automatic do_recover(input int id);
    recover_i = 1'b1; recover_id_i = CK_W'(id);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    idle(); rd(5, 0);
    expect_(K_V0, 0, "reset_val"); expect_(K_T0, 0, "reset_tag"); expect_(K_FULL, 0, "reset_full");
    next();

    // Mid-run asynchronous reset with Q[5]=3 and two live checkpoints
    idle(); alloc(5, 3); ckpt_req_i = 1'b1;
    expect_(K_ACK, 1, "t1_ack0"); expect_(K_ID, 0, "t1_id0");
    next();
    idle(); ckpt_req_i = 1'b1; rd(5, 0);
    expect_(K_T0, 3, "t1_q5_before"); expect_(K_ID, 1, "t1_id1");
    next();
    idle(); ckpt_req_i = 1'b1; rd(5, 0);
    #1 rst = 1'b1;
    expect_(K_T0, 0, "t1_async_tag"); expect_(K_FULL, 0, "t1_async_full");
    expect_(K_ACK, 0, "t1_async_ack");
    next();
    idle(); rst = 1'b0;

    // Commit bypass on the read ports
    alloc(5, 3);
    next();
    idle(); do_commit(5, 3, 32'hAB); rd(5, 5);
    expect_(K_V0, 32'hAB, "t2_byp_val0"); expect_(K_T0, 0, "t2_byp_tag0");
    expect_(K_V1, 32'hAB, "t2_byp_val1"); expect_(K_T1, 0, "t2_byp_tag1");
    next();
    idle(); rd(5, 0);
    expect_(K_V0, 32'hAB, "t2_v5"); expect_(K_T0, 0, "t2_q5");
    next();

    // Alloc beats commit-clear on the same register
    idle(); alloc(5, 3);
    next();
    idle(); alloc(5, 4); do_commit(5, 3, 32'h55); rd(5, 0);
    expect_(K_V0, 32'h55, "t3_byp_val"); expect_(K_T0, 0, "t3_byp_tag");
    next();
    idle(); rd(5, 0);
    expect_(K_V0, 32'h55, "t3_v5"); expect_(K_T0, 4, "t3_alloc_wins");
    next();
    idle(); do_commit(5, 9, 32'h66); rd(5, 0);
    expect_(K_V0, 32'h66, "t3_stale_val"); expect_(K_T0, 4, "t3_stale_tag");
    next();
    idle(); do_commit(5, 4, 32'h77); rd(0, 5);
    expect_(K_V1, 32'h77, "t3_final_val"); expect_(K_T1, 0, "t3_final_tag");
    next();
    idle(); alloc(0, 5); rd(0, 5);
    expect_(K_V1, 32'h77, "t3_v5_kept"); expect_(K_T0, 0, "x0_alloc_tag");
    next();
    idle(); do_commit(0, 0, 32'h99); rd(0, 0);
    expect_(K_V0, 0, "x0_commit_val"); expect_(K_T0, 0, "x0_commit_tag");
    next();
    idle(); rd(0, 0);
    expect_(K_V0, 0, "x0_after_val"); expect_(K_T0, 0, "x0_after_tag");
    next();

    // Checkpoint, younger alloc, commit-clear into the snapshot, recover
    idle(); alloc(7, 2);
    next();
    idle(); ckpt_req_i = 1'b1;
    expect_(K_ACK, 1, "t4_ack"); expect_(K_ID, 0, "t4_id0");
    next();
    idle(); alloc(7, 6); rd(7, 0);
    expect_(K_T0, 2, "t4_alloc_invisible");
    next();
    idle(); do_commit(7, 2, 32'h22); rd(7, 0);
    expect_(K_V0, 32'h22, "t4_commit_val"); expect_(K_T0, 6, "t4_commit_tag");
    next();
    idle(); do_recover(0); rd(7, 0);
    expect_(K_T0, 6, "t4_pre_recover");
    next();
    idle(); rd(7, 0); ckpt_req_i = 1'b1;
    expect_(K_T0, 0, "t4_restored_tag"); expect_(K_V0, 32'h22, "t4_restored_val");
    expect_(K_ACK, 1, "t4_ack_after"); expect_(K_ID, 1, "t4_tail");
    next();
    idle(); ckpt_req_i = 1'b1;
    expect_(K_ID, 2, "t4_id2"); expect_(K_FULL, 0, "t4_full2");
    next();
    idle(); ckpt_req_i = 1'b1;
    expect_(K_ID, 3, "t4_id3"); expect_(K_FULL, 0, "t4_full3");
    next();

    // Full ring, then release+request wraps to slot 0
    idle(); ckpt_req_i = 1'b1;
    expect_(K_FULL, 1, "t5_full"); expect_(K_ACK, 0, "t5_nack");
    next();
    idle(); ckpt_req_i = 1'b1; release_i = 1'b1;
    expect_(K_ACK, 1, "t5_rel_ack"); expect_(K_ID, 0, "t5_wrap_id");
    next();

    // Recover with release applied first; alloc and request dropped
    idle(); do_recover(2); release_i = 1'b1; alloc(9, 7); ckpt_req_i = 1'b1;
    expect_(K_ACK, 0, "rec_drop_ack"); expect_(K_FULL, 1, "rec_full_before");
    next();
    idle(); rd(9, 0); ckpt_req_i = 1'b1;
    expect_(K_T0, 0, "rec_drop_alloc"); expect_(K_ACK, 1, "rec_ack");
    expect_(K_ID, 3, "rec_tail"); expect_(K_FULL, 0, "rec_count");
    next();

    // Flush dominates recover/alloc/request but keeps the commit value
    idle(); alloc(3, 5);
    next();
    idle(); flush_i = 1'b1; do_recover(2); alloc(4, 8); ckpt_req_i = 1'b1;
    do_commit(3, 1, 32'h3C); rd(3, 4);
    expect_(K_ACK, 0, "t6_ack"); expect_(K_V0, 32'h3C, "t6_byp_val"); expect_(K_T0, 5, "t6_byp_tag");
    next();
    idle(); rd(3, 4);
    expect_(K_V0, 32'h3C, "t6_v3"); expect_(K_T0, 0, "t6_q3");
    expect_(K_T1, 0, "t6_q4"); expect_(K_FULL, 0, "t6_full");
    next();
    for (int i = 0; i < NUM_CKPT; i++) begin
      idle(); ckpt_req_i = 1'b1;
      expect_(K_ACK, 1, $sformatf("t6_refill_ack%0d", i));
      expect_(K_ID, 32'(i), $sformatf("t6_refill_id%0d", i));
      next();
    end

    // rdy low freezes all state and forces ack low
    idle(); rdy = 1'b0; ckpt_req_i = 1'b1; release_i = 1'b1; alloc(10, 3);
    expect_(K_FULL, 1, "rdy0_full"); expect_(K_ACK, 0, "rdy0_ack");
    next();
    idle(); rd(10, 0);
    expect_(K_T0, 0, "rdy0_alloc"); expect_(K_FULL, 1, "rdy0_hold");
    next();

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
